// File: rtl/eco32_bus_pkg.sv
// ----------------------------------------------------------------------------
// eco32_bus_pkg
// Shared definitions for the eco32 native bus to Wishbone bridge family:
//   - size encodings of the eco32 bus_size field
//   - bridge state enumeration
//   - big-endian lane helpers: byte-select generation, alignment check,
//     write-data replication and read-data lane replication
// No ports (package).
// ----------------------------------------------------------------------------
package eco32_bus_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_BAD  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_DONE   = 2'b10
    } state_e;

    // Big-endian byte selects: lane 0 (sel[3]) carries address offset 0.
    function automatic logic [3:0] lane_sel(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [3:0] sel;
        case (size)
            SZ_BYTE: sel = 4'b1000 >> addr_lo;
            SZ_HALF: sel = addr_lo[1] ? 4'b0011 : 4'b1100;
            SZ_WORD: sel = 4'b1111;
            default: sel = 4'b0000;
        endcase
        return sel;
    endfunction

    // Illegal size or a halfword/word not on its natural boundary.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Right-justified CPU data replicated onto every lane it could occupy.
    function automatic logic [31:0] wdata_rep(input logic [1:0] size, input logic [31:0] data);
        logic [31:0] rep;
        case (size)
            SZ_BYTE: rep = {4{data[7:0]}};
            SZ_HALF: rep = {2{data[15:0]}};
            default: rep = data;
        endcase
        return rep;
    endfunction

    // The active lane(s) of the slave word replicated across all 32 bits.
    function automatic logic [31:0] rdata_rep(input logic [3:0] sel, input logic [31:0] data);
        logic [31:0] rep;
        case (sel)
            4'b1000: rep = {4{data[31:24]}};
            4'b0100: rep = {4{data[23:16]}};
            4'b0010: rep = {4{data[15:8]}};
            4'b0001: rep = {4{data[7:0]}};
            4'b1100: rep = {2{data[31:16]}};
            4'b0011: rep = {2{data[15:0]}};
            default: rep = data;
        endcase
        return rep;
    endfunction

endpackage

// File: rtl/eco32_wb_bridge_if.sv
// ----------------------------------------------------------------------------
// eco32_wb_bridge_if
// Wishbone B3 classic master bundle used by the eco32 bridge.
//   master modport : bridge side (drives adr/dat/sel/we/cyc/stb/cti/bte)
//   slave  modport : interconnect/slave side (drives dat_i/ack/err/rty)
// ----------------------------------------------------------------------------
interface eco32_wb_bridge_if;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic        wbm_we_o;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic [2:0]  wbm_cti_o;
    logic [1:0]  wbm_bte_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;
    logic        wbm_err_i;
    logic        wbm_rty_i;

    modport master (
        output wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o,
               wbm_stb_o, wbm_cti_o, wbm_bte_o,
        input  wbm_dat_i, wbm_ack_i, wbm_err_i, wbm_rty_i
    );

    modport slave (
        input  wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o,
               wbm_stb_o, wbm_cti_o, wbm_bte_o,
        output wbm_dat_i, wbm_ack_i, wbm_err_i, wbm_rty_i
    );
endinterface

// File: rtl/eco32_lane_steer.sv
// ----------------------------------------------------------------------------
// eco32_lane_steer
// Combinational big-endian lane steering for eco32 bus bridges.
//   size_i, addr_lo_i : request size and address offset
//   wdata_i           : right-justified CPU write data
//   rd_sel_i          : byte selects of the registered access
//   rdata_i           : raw slave read word
//   sel_o             : byte selects for the request
//   wdata_o           : write data replicated across lanes
//   rdata_o           : selected read lane(s) replicated across the word
//   misaligned_o      : request is illegal or misaligned
// ----------------------------------------------------------------------------
module eco32_lane_steer
    import eco32_bus_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  rd_sel_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  sel_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        misaligned_o
);

    assign sel_o        = lane_sel(size_i, addr_lo_i);
    assign wdata_o      = wdata_rep(size_i, wdata_i);
    assign rdata_o      = rdata_rep(rd_sel_i, rdata_i);
    assign misaligned_o = misaligned(size_i, addr_lo_i);

endmodule

// File: rtl/eco32_wb_bridge.sv
// ----------------------------------------------------------------------------
// eco32_wb_bridge
// Registered bridge from the eco32 native bus to a Wishbone B3 classic master.
//   wb_clk_i, wb_rst_i : clock, synchronous active-high reset
//   bus_en/wr/size/addr/data_out : CPU request (held until bus_wt=0)
//   bus_data_in, bus_wt, bus_err : CPU response; bus_wt low one cycle per access
//   wbm                : Wishbone master bundle (eco32_wb_bridge_if.master)
// Parameters:
//   TIMEOUT_CYCLES : cycles with cyc high before abort (0 = never abort)
//   ERR_DATA       : read data returned on any failed access
// ----------------------------------------------------------------------------
module eco32_wb_bridge
    import eco32_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_DATA       = 32'h0000_0000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        bus_en,
    input  logic        bus_wr,
    input  logic [1:0]  bus_size,
    input  logic [31:0] bus_addr,
    input  logic [31:0] bus_data_out,
    output logic [31:0] bus_data_in,
    output logic        bus_wt,
    output logic        bus_err,
    eco32_wb_bridge_if.master wbm
);

    // A zero-width counter is not legal, so the disabled case keeps one bit.
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 32'd1) : 32'd0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);

    state_e            state_q, state_d;
    logic [31:0]       adr_q, adr_d;
    logic [31:0]       dat_q, dat_d;
    logic [3:0]        sel_q, sel_d;
    logic              we_q, we_d;
    logic              cyc_q, cyc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              wt_q, wt_d;
    logic              err_q, err_d;

    logic [3:0]        req_sel;
    logic [31:0]       req_wdata;
    logic [31:0]       rd_steer;
    logic              req_bad;
    logic              timeout_hit;
    logic              abort;

    eco32_lane_steer u_steer (
        .size_i       (bus_size),
        .addr_lo_i    (bus_addr[1:0]),
        .wdata_i      (bus_data_out),
        .rd_sel_i     (sel_q),
        .rdata_i      (wbm.wbm_dat_i),
        .sel_o        (req_sel),
        .wdata_o      (req_wdata),
        .rdata_o      (rd_steer),
        .misaligned_o (req_bad)
    );

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_timeout
            assign timeout_hit = (cnt_q == CNT_LAST);
        end else begin : g_no_timeout
            assign timeout_hit = 1'b0;
        end
    endgenerate

    // Retry is not retried here; it terminates the access like err.
    assign abort = wbm.wbm_err_i | wbm.wbm_rty_i | timeout_hit;

    // Next-state and datapath: bus_wt/bus_err are precomputed so they leave flops.
    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        we_d    = we_q;
        cyc_d   = cyc_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        wt_d    = 1'b1;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus_en) begin
                    if (req_bad) begin
                        rdata_d = ERR_DATA;
                        err_d   = 1'b1;
                        wt_d    = 1'b0;
                        state_d = ST_DONE;
                    end else begin
                        adr_d   = bus_addr;
                        we_d    = bus_wr;
                        sel_d   = req_sel;
                        dat_d   = req_wdata;
                        cyc_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_ACCESS;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                cnt_d = cnt_q + CNT_ONE;
                // ack wins over err/rty/timeout in the same cycle.
                if (wbm.wbm_ack_i) begin
                    cyc_d   = 1'b0;
                    wt_d    = 1'b0;
                    state_d = ST_DONE;
                    if (we_q) begin
                        rdata_d = rdata_q;
                    end else begin
                        rdata_d = rd_steer;
                    end
                end else if (abort) begin
                    cyc_d   = 1'b0;
                    rdata_d = ERR_DATA;
                    err_d   = 1'b1;
                    wt_d    = 1'b0;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_ACCESS;
                end
            end
            ST_DONE: begin
                // bus_en still high here belongs to the completed request.
                state_d = ST_IDLE;
            end
            default: begin
                cyc_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            adr_q   <= 32'h0000_0000;
            dat_q   <= 32'h0000_0000;
            sel_q   <= 4'b0000;
            we_q    <= 1'b0;
            cyc_q   <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= 32'h0000_0000;
            wt_q    <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            cyc_q   <= cyc_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            wt_q    <= wt_d;
            err_q   <= err_d;
        end
    end

    assign bus_data_in   = rdata_q;
    assign bus_wt        = wt_q;
    assign bus_err       = err_q;

    assign wbm.wbm_adr_o = adr_q;
    assign wbm.wbm_dat_o = dat_q;
    assign wbm.wbm_sel_o = sel_q;
    assign wbm.wbm_we_o  = we_q;
    assign wbm.wbm_cyc_o = cyc_q;
    assign wbm.wbm_stb_o = cyc_q;
    assign wbm.wbm_cti_o = 3'b000;
    assign wbm.wbm_bte_o = 2'b00;

endmodule

// File: doc/eco32_wb_bridge.md
Name: eco32_wb_bridge

Overview:
Registered bridge between the eco32 CPU native bus (en/wr/size/addr/data/wt) and a Wishbone B3 classic master port on the system interconnect. It replaces ad-hoc combinational glue with a state machine that:
- registers the request and performs big-endian byte-lane steering;
- captures read data on ack;
- terminates hung, errored or misaligned accesses with a bus error.

It sits directly upstream of the wb_intercon eco32f_d master port.

Parameters:
TIMEOUT_CYCLES, 255, max cycles with cyc asserted before the bridge aborts the access; 0 disables the timeout.
ERR_DATA, 32'h0000_0000, read data returned to the CPU on error, timeout or misalignment.

Ports:
wb_clk_i  input  1  system clock
wb_rst_i  input  1  synchronous active-high reset
bus_en  input  1  CPU request valid, held until the cycle bus_wt=0
bus_wr  input  1  1=write, 0=read
bus_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal
bus_addr  input  32  byte address
bus_data_out  input  32  CPU write data, right-justified
bus_data_in  output  32  read data to CPU, valid only when bus_wt=0
bus_wt  output  1  wait; 0 for exactly one cycle to complete an access
bus_err  output  1  one-cycle pulse coincident with bus_wt=0 on a failed access
wbm_adr_o  output  32  Wishbone address (bus_addr, unmodified)
wbm_dat_o  output  32  write data replicated across lanes
wbm_sel_o  output  4  byte selects, big-endian
wbm_we_o  output  1  write enable
wbm_cyc_o  output  1  cycle
wbm_stb_o  output  1  strobe (equal to cyc)
wbm_cti_o  output  3  constant 000
wbm_bte_o  output  2  constant 00
wbm_dat_i  input  32  read data
wbm_ack_i  input  1  ack
wbm_err_i  input  1  error
wbm_rty_i  input  1  retry (treated as error)

Behaviour:
- Reset: all outputs are driven during reset as follows.
  - State IDLE.
  - cyc/stb/we = 0; adr, dat and sel = 0.
  - bus_wt = 1, bus_err = 0, bus_data_in = 0, timeout counter = 0.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - bus_wt = 1.
  - On bus_en with a legal, aligned request: register adr/we/sel/dat, assert cyc/stb next cycle, go to ACCESS.
  - On an illegal request (size 11, halfword with addr[0]=1, word with addr[1:0]≠0): no Wishbone cycle; load ERR_DATA, set err flag, go to DONE.
- Lane steering (big-endian):
  - Byte: sel = 1000 >> addr[1:0]; dat = {4{data[7:0]}}.
  - Halfword: sel = addr[1] ? 0011 : 1100; dat = {2{data[15:0]}}.
  - Word: sel = 1111; dat = data.
- ACCESS:
  - cyc/stb held with stable adr/dat/sel/we; the counter increments each cycle.
  - Termination priority: ack > err/rty > timeout.
  - On ack: capture steered read data, drop cyc/stb on the next edge, go to DONE with err flag 0.
  - On err or rty: drop cyc, load ERR_DATA, set err flag, go to DONE.
  - On timeout (counter reaches TIMEOUT_CYCLES-1 without termination): same as err.
- Read steering: the selected lane is replicated across the word.
  - Byte lane k: {4{lane k}}.
  - Halfword: {2{half}}.
  - Word: unmodified.
  - Writes return the previous bus_data_in value; it is don't-care for the CPU.
- DONE: bus_wt = 0 and bus_err = err flag for exactly one cycle, then IDLE unconditionally. bus_en still high during DONE is the same request and is not re-accepted.
- Latency:
  - Request seen at edge 0 → cyc high after edge 1.
  - With ack on the first cyc cycle, bus_wt=0 during cycle 2; minimum 3 cycles per access.
  - There is one dead IDLE cycle between back-to-back accesses.
- Boundary conditions:
  - A late ack arriving after a timeout abort (cyc=0) is ignored.
  - bus_en dropping during ACCESS is a CPU protocol violation; the access completes regardless.
  - Reset during ACCESS: cyc drops at that edge, no completion is reported.
  - The counter is cleared on entry to ACCESS; its width is $clog2(TIMEOUT_CYCLES+1).

Decomposition:
- Package eco32_bus_pkg holds:
  - size encodings (SZ_BYTE, SZ_HALF, SZ_WORD);
  - state enum;
  - functions lane_sel(size, addr[1:0]), misaligned(size, addr[1:0]), wdata_rep(size, data), rdata_rep(sel, data).
- One sub-module is natural: eco32_lane_steer, combinational, computing sel, write replication and read extraction, shared with a future instruction-fetch bridge.

Test Plan:
- Word read at 0x0000_0010: slave acks 2 cycles after cyc with 0xDEADBEEF → sel 1111, bus_data_in 0xDEADBEEF, bus_wt low exactly one cycle, bus_err 0.
- Byte write of 0xA5 at 0x...03 → sel 0001, dat 0xA5A5A5A5, we 1; byte read at 0x...01 with wbm_dat_i 0x11223344 → sel 0100, bus_data_in 0x22222222.
- Halfword read at 0x...02 with 0x11223344 → sel 0011, bus_data_in 0x33443344; halfword at 0x...01 → no cyc, bus_err pulse, data ERR_DATA, completion 2 cycles after bus_en.
- Slave asserts err, then separately rty → cyc drops the next edge, bus_err pulse, bus_data_in 0.
- TIMEOUT_CYCLES=8, slave never acks → cyc high 8 cycles, then bus_err; an ack injected afterwards causes no second completion.
- Reset asserted on the third ACCESS cycle → cyc 0 and bus_wt 1 after that edge; the next bus_en starts a clean access.
